// File: rtl/exec_stage.sv
// exec_stage: single-cycle ALU execute stage with valid/ready handshakes.
// Results are held in an output register backed by one skid register, so
// in_ready comes straight from a flop and back-to-back ops flow at 1/cycle.
// op_count tracks retired results and wraps at 16 bits.
module exec_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [RD_W-1:0]   out_rd,
  output logic [15:0]       op_count
);

  // ALU: unknown codes produce zero and are not treated as errors.
  function automatic logic [DATA_W-1:0] alu(input logic [3:0] ctrl,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (ctrl)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_zero_q, out_zero_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_result_q, skid_result_d;
  logic              skid_zero_q, skid_zero_d;
  logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              accept_s;
  logic              retire_s;
  logic [DATA_W-1:0] new_result_s;
  logic              new_zero_s;

  // Handshake decode and result computed in the accepting cycle.
  always_comb begin
    accept_s     = in_valid & ~skid_valid_q;
    retire_s     = out_valid_q & out_ready;
    new_result_s = alu(in_ctrl, in_a, in_b);
    new_zero_s   = (new_result_s == {DATA_W{1'b0}});
  end

  // Next-state for the two entries and the retire counter.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_rd_d      = out_rd_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_zero_d   = skid_zero_q;
    skid_rd_d     = skid_rd_q;
    op_count_d    = op_count_q;

    if (retire_s) begin
      out_valid_d = 1'b0;
      op_count_d  = op_count_q + 16'd1;
    end else begin
      op_count_d  = op_count_q;
    end

    // A full skid blocks acceptance, so promotion and acceptance never collide.
    if (skid_valid_q && retire_s) begin
      out_valid_d  = 1'b1;
      out_result_d = skid_result_q;
      out_zero_d   = skid_zero_q;
      out_rd_d     = skid_rd_q;
      skid_valid_d = 1'b0;
    end else if (accept_s && (!out_valid_q || retire_s)) begin
      out_valid_d  = 1'b1;
      out_result_d = new_result_s;
      out_zero_d   = new_zero_s;
      out_rd_d     = in_rd;
    end else if (accept_s) begin
      skid_valid_d  = 1'b1;
      skid_result_d = new_result_s;
      skid_zero_d   = new_zero_s;
      skid_rd_d     = in_rd;
    end else begin
      skid_valid_d  = skid_valid_q;
    end

    // Flush drops everything held, including an op accepted this cycle.
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      skid_valid_d = skid_valid_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= {DATA_W{1'b0}};
      out_zero_q    <= 1'b1;
      out_rd_q      <= {RD_W{1'b0}};
      skid_valid_q  <= 1'b0;
      skid_result_q <= {DATA_W{1'b0}};
      skid_zero_q   <= 1'b1;
      skid_rd_q     <= {RD_W{1'b0}};
      op_count_q    <= 16'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_rd_q      <= out_rd_d;
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_zero_q   <= skid_zero_d;
      skid_rd_q     <= skid_rd_d;
      op_count_q    <= op_count_d;
    end
  end

  assign in_ready   = ~skid_valid_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_rd     = out_rd_q;
  assign op_count   = op_count_q;

endmodule
